// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: operation codes,
// controller state encoding and default datapath widths.
package alu_seq_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int SHAMT_W_DEF = 4;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_SUB   = 3'd1;
    localparam logic [2:0] FN_AND   = 3'd2;
    localparam logic [2:0] FN_OR    = 3'd3;
    localparam logic [2:0] FN_XOR   = 3'd4;
    localparam logic [2:0] FN_NOTA  = 3'd5;
    localparam logic [2:0] FN_PASSB = 3'd6;
    localparam logic [2:0] FN_SHL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU. Shift-left is sequenced outside this block,
// so the SHL code simply produces zero here.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [2:0]       func_i,
    output logic [WIDTH-1:0] w_o
);

    logic [WIDTH-1:0] cin_ext_s;

    assign cin_ext_s = {{(WIDTH-1){1'b0}}, cin_i};

    // Select the operation result; carry-out is dropped by the result width.
    always_comb begin
        w_o = {WIDTH{1'b0}};
        case (func_i)
            FN_ADD:   w_o = a_i + b_i + cin_ext_s;
            FN_SUB:   w_o = a_i + ~b_i + cin_ext_s;
            FN_AND:   w_o = a_i & b_i;
            FN_OR:    w_o = a_i | b_i;
            FN_XOR:   w_o = a_i ^ b_i;
            FN_NOTA:  w_o = ~a_i;
            FN_PASSB: w_o = b_i;
            default:  w_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked front end for the ALU: accepts one request, runs it (single
// cycle through alu_core, or one bit per cycle for shift-left), and holds the
// registered result with its flags until the consumer takes it.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic [2:0]       req_func,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_zero,
    output logic             rsp_neg
);

    state_e               state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_w_q, rsp_w_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic                 rsp_neg_q, rsp_neg_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 cin_q, cin_d;

    logic [WIDTH-1:0]     core_w_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 wr_s;
    logic [WIDTH-1:0]     wr_val_s;

    assign shamt_s = req_b[SHAMT_W-1:0];

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a_i    (req_a),
        .b_i    (req_b),
        .cin_i  (req_cin),
        .func_i (req_func),
        .w_o    (core_w_s)
    );

    // Next-state, handshake and result-write decode for the controller.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        cin_d       = cin_q;
        wr_s        = 1'b0;
        wr_val_s    = {WIDTH{1'b0}};

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    cin_d = req_cin;
                    if (req_func != FN_SHL) begin
                        wr_s     = 1'b1;
                        wr_val_s = core_w_s;
                    end else if (shamt_s == {SHAMT_W{1'b0}}) begin
                        wr_s     = 1'b1;
                        wr_val_s = req_a;
                    end else begin
                        sh_d        = req_a;
                        cnt_d       = shamt_s;
                        req_ready_d = 1'b0;
                        state_d     = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                req_ready_d = 1'b0;
                sh_d        = {sh_q[WIDTH-2:0], cin_q};
                cnt_d       = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
                // A zero count here is unreachable; finishing keeps it from wrapping.
                if (cnt_q <= {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    wr_s     = 1'b1;
                    wr_val_s = sh_d;
                    cnt_d    = {SHAMT_W{1'b0}};
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    req_ready_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                cnt_d       = {SHAMT_W{1'b0}};
            end
        endcase

        // Result and flags change only when a result is written.
        if (wr_s) begin
            rsp_w_d     = wr_val_s;
            rsp_zero_d  = (wr_val_s == {WIDTH{1'b0}});
            rsp_neg_d   = wr_val_s[WIDTH-1];
            rsp_valid_d = 1'b1;
            req_ready_d = 1'b0;
            state_d     = ST_DONE;
        end else begin
            rsp_w_d    = rsp_w_q;
            rsp_zero_d = rsp_zero_q;
            rsp_neg_d  = rsp_neg_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_w_q     <= {WIDTH{1'b0}};
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            sh_q        <= {WIDTH{1'b0}};
            cnt_q       <= {SHAMT_W{1'b0}};
            cin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_w_q     <= rsp_w_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_w     = rsp_w_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_neg   = rsp_neg_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random-regression bench for alu_op_sequencer.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic [2:0]  req_func;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_w;
    logic        rsp_zero;
    logic        rsp_neg;

    int checks;
    int errors;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_func  (req_func),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_w     (rsp_w),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic [2:0] func);
        logic [15:0] r;
        case (func)
            3'd0: r = a + b + {15'd0, cin};
            3'd1: r = a - b - 16'd1 + {15'd0, cin};
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = b;
            default: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], cin};
            end
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance; returns 1 cycle after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [2:0] func);
        int n;
        req_a = a; req_b = b; req_cin = cin; req_func = func; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        step();
        req_valid = 1'b0;
    endtask

    // Take the current response.
    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_a = 16'h0001; req_b = 16'h0002;
        req_cin = 1'b0; req_func = 3'd0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_w !== 16'h0000 || rsp_zero !== 1'b0 || rsp_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b w=%h z=%b n=%b, required 0 0000 0 0", rsp_valid, rsp_w, rsp_zero, rsp_neg);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_rsp: rsp_valid=%b cycle %0d, required 0", rsp_valid, i);
            end
        end
        // Abort a shift mid-way with reset.
        send(16'h0003, 16'h0008, 1'b0, 3'd7);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_abort: valid=%b ready=%b cycle %0d, required 0 1", rsp_valid, req_ready, i);
            end
            step();
        end
    endtask

    task automatic test_add_wrap();
        send(16'hFFFF, 16'h0001, 1'b0, 3'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h0000 || rsp_zero !== 1'b1 || rsp_neg !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: valid=%b w=%h z=%b n=%b, required 1 0000 1 0", rsp_valid, rsp_w, rsp_zero, rsp_neg);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_ready_low: req_ready=%b, required 0", req_ready);
        end
        consume();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_sub();
        send(16'd5, 16'd7, 1'b1, 3'd1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'hFFFE || rsp_zero !== 1'b0 || rsp_neg !== 1'b1) begin
            errors++;
            $display("FAIL sub: valid=%b w=%h z=%b n=%b, required 1 fffe 0 1", rsp_valid, rsp_w, rsp_zero, rsp_neg);
        end
        consume();
        send(16'h1234, 16'h0000, 1'b0, 3'd5);
        checks++;
        if (rsp_w !== 16'hEDCB || rsp_neg !== 1'b1) begin
            errors++;
            $display("FAIL nota: w=%h n=%b, required edcb 1", rsp_w, rsp_neg);
        end
        consume();
    endtask

    task automatic test_shl_latency();
        int n;
        send(16'h0001, 16'd4, 1'b1, 3'd7);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL shl4_wait: valid=%b ready=%b cycle %0d, required 0 0", rsp_valid, req_ready, c);
            end
            step();
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h001F || rsp_zero !== 1'b0 || rsp_neg !== 1'b0) begin
            errors++;
            $display("FAIL shl4_result: valid=%b w=%h z=%b n=%b, required 1 001f 0 0", rsp_valid, rsp_w, rsp_zero, rsp_neg);
        end
        consume();
        // Maximum shift amount: 16 cycles.
        send(16'h0001, 16'h000F, 1'b0, 3'd7);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 16 || rsp_w !== 16'h8000 || rsp_neg !== 1'b1) begin
            errors++;
            $display("FAIL shl15: latency=%0d w=%h n=%b, required 16 8000 1", n, rsp_w, rsp_neg);
        end
        consume();
        // Zero shift amount (upper b bits ignored): passes a, latency 1.
        send(16'hA5A5, 16'h0010, 1'b1, 3'd7);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'hA5A5) begin
            errors++;
            $display("FAIL shl0: valid=%b w=%h, required 1 a5a5", rsp_valid, rsp_w);
        end
        consume();
    endtask

    task automatic test_backpressure();
        send(16'hF0F0, 16'h0FF0, 1'b0, 3'd2);
        req_a = 16'h1234; req_b = 16'h00FF; req_cin = 1'b0; req_func = 3'd4; req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_w !== 16'h00F0 || rsp_zero !== 1'b0 || rsp_neg !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b w=%h z=%b n=%b ready=%b cycle %0d, required 1 00f0 0 0 0",
                         rsp_valid, rsp_w, rsp_zero, rsp_neg, req_ready, c);
            end
            step();
        end
        consume();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_w !== 16'h12CB) begin
            errors++;
            $display("FAIL bp_next: valid=%b w=%h, required 1 12cb", rsp_valid, rsp_w);
        end
        consume();
    endtask

    task automatic test_random();
        logic [15:0] a, b, exp_w;
        logic        cin, got;
        logic [2:0]  fn;
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); fn = 3'($urandom_range(0, 7));
            exp_w = ref_model(a, b, cin, fn);
            send(a, b, cin, fn);
            got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                if (rsp_valid === 1'b1 && rsp_ready) begin
                    got = 1'b1;
                    checks++;
                    if (rsp_w !== exp_w || rsp_zero !== (exp_w == 16'h0000) || rsp_neg !== exp_w[15]) begin
                        errors++;
                        $display("FAIL rand_%0d: fn=%0d a=%h b=%h cin=%b w=%h z=%b n=%b, required %h",
                                 i, fn, a, b, cin, rsp_w, rsp_zero, rsp_neg, exp_w);
                    end
                end
                step();
            end
            rsp_ready = 1'b0;
            checks++;
            if (!got || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_hs_%0d: got=%b rsp_valid_after=%b, required 1 0", i, got, rsp_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 16'h0000; req_b = 16'h0000; req_cin = 1'b0; req_func = 3'd0;
        test_reset();
        test_add_wrap();
        test_sub();
        test_shl_latency();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
